// File: rtl/ppu_vram_oam_responder_if.sv
// Bus bundle between the PPU / CPU MMIO / system-bus side and the VRAM+OAM
// responder. Signal names follow the existing PPU-side net names.
interface ppu_vram_oam_responder_if;
  logic        LCD_EN;
  logic [1:0]  PPU_MODE;
  logic        PPU_RD;
  logic [15:0] PPU_ADDR;
  logic [7:0]  PPU_DATA_in;
  logic [15:0] ADDR;
  logic        RD;
  logic        WR;
  logic [7:0]  MMIO_DATA_out;
  logic [7:0]  MEM_DATA_in;
  logic        MEM_HIT;
  logic        DMA_RD;
  logic [15:0] DMA_ADDR;
  logic [7:0]  DMA_DATA;
  logic        DMA_ACTIVE;

  // Requesting side: PPU, CPU and the system-bus data return.
  modport master (
    output LCD_EN, PPU_MODE, PPU_RD, PPU_ADDR, ADDR, RD, WR, MMIO_DATA_out, DMA_DATA,
    input  PPU_DATA_in, MEM_DATA_in, MEM_HIT, DMA_RD, DMA_ADDR, DMA_ACTIVE
  );

  // Memory-side responder.
  modport slave (
    input  LCD_EN, PPU_MODE, PPU_RD, PPU_ADDR, ADDR, RD, WR, MMIO_DATA_out, DMA_DATA,
    output PPU_DATA_in, MEM_DATA_in, MEM_HIT, DMA_RD, DMA_ADDR, DMA_ACTIVE
  );
endinterface

// File: rtl/ppu_vram_oam_responder.sv
// VRAM (8000-9FFF) and OAM (FE00-FE9F) responder: two-cycle PPU read pipe,
// mode-based CPU locking, and the FF46 OAM DMA copy engine.
// Optional feature macro: PPU_MEM_DMA_EN (DMA engine + FF46 shadow present).
module ppu_vram_oam_responder #(
  parameter int VRAM_AW  = 13,
  parameter int OAM_SIZE = 160
) (
  input  logic                     clk,
  input  logic                     rst,
  ppu_vram_oam_responder_if.slave  bus
);
  localparam int         VRAM_BYTES = 1 << VRAM_AW;
  localparam logic [7:0] OAM_LAST   = 8'(OAM_SIZE - 1);

  typedef enum logic [1:0] {SRC_NONE, SRC_VRAM, SRC_OAM} ppu_src_t;

  function automatic logic is_vram(input logic [15:0] a);
    return a[15:13] == 3'b100;
  endfunction

  function automatic logic is_oam(input logic [15:0] a);
    return (a[15:8] == 8'hFE) && (a[7:0] <= OAM_LAST);
  endfunction

  logic [7:0] vram [VRAM_BYTES];
  logic [7:0] oam  [OAM_SIZE];

  logic       cpu_vram_hit, cpu_oam_hit, cpu_ff46_hit;
  logic       vram_lock, oam_lock;
  logic       vram_we, cpu_oam_we;
  logic       dma_active, dma_we;
  logic [7:0] dma_idx, dma_src;
  logic [7:0] cpu_rd_data, mem_data_q;
  ppu_src_t   ppu_src, s1_src;
  logic       s1_valid;
  logic [7:0] s1_vram, s1_oam, ppu_data_q;

  assign cpu_vram_hit = is_vram(bus.ADDR);
  assign cpu_oam_hit  = is_oam(bus.ADDR);
  assign bus.MEM_HIT  = cpu_vram_hit || cpu_oam_hit || cpu_ff46_hit;

  // With the LCD off the CPU owns both RAMs; a running DMA always owns OAM.
  assign vram_lock  = bus.LCD_EN && (bus.PPU_MODE == 2'd3);
  assign oam_lock   = (bus.LCD_EN && bus.PPU_MODE[1]) || dma_active;
  assign vram_we    = bus.WR && cpu_vram_hit && !vram_lock;
  assign cpu_oam_we = bus.WR && cpu_oam_hit && !oam_lock;

  // Classify the PPU address; OAM is hidden from the PPU while DMA copies.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    ppu_src = SRC_NONE;
    if (is_vram(bus.PPU_ADDR))                     ppu_src = SRC_VRAM;
    else if (is_oam(bus.PPU_ADDR) && !dma_active)  ppu_src = SRC_OAM;
  end

  // RAM arrays: CPU/DMA write ports and the PPU stage-1 synchronous read.
  // A same-edge CPU write and PPU read of one VRAM byte returns the old byte.
  always_ff @(posedge clk) begin
    // NOTE: RAM contents are deliberately left unreset; only control state is reset.
    if (vram_we) vram[bus.ADDR[VRAM_AW-1:0]] <= bus.MMIO_DATA_out;
    if (dma_we)          oam[dma_idx]       <= bus.DMA_DATA;
    else if (cpu_oam_we) oam[bus.ADDR[7:0]] <= bus.MMIO_DATA_out;
    if (bus.PPU_RD) begin
      s1_vram <= vram[bus.PPU_ADDR[VRAM_AW-1:0]];
      if (ppu_src == SRC_OAM) s1_oam <= oam[bus.PPU_ADDR[7:0]];
    end
  end

  // PPU pipe control and output register; the output holds between reads.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_src     <= SRC_NONE;
      ppu_data_q <= 8'hFF;
    end else begin
      s1_valid <= bus.PPU_RD;
      if (bus.PPU_RD) s1_src <= ppu_src;
      if (s1_valid) begin
        case (s1_src)
          SRC_VRAM: ppu_data_q <= s1_vram;
          SRC_OAM:  ppu_data_q <= s1_oam;
          default:  ppu_data_q <= 8'hFF;
        endcase
      end
    end
  end

  assign bus.PPU_DATA_in = ppu_data_q;

  // CPU read mux: locked or unmapped addresses read as FF.
  always_comb begin
    cpu_rd_data = 8'hFF;
    if (cpu_vram_hit && !vram_lock)     cpu_rd_data = vram[bus.ADDR[VRAM_AW-1:0]];
    else if (cpu_oam_hit && !oam_lock)  cpu_rd_data = oam[bus.ADDR[7:0]];
    else if (cpu_ff46_hit)              cpu_rd_data = dma_src;
  end

  // CPU read data register, valid the cycle after RD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         mem_data_q <= 8'hFF;
    else if (bus.RD) mem_data_q <= cpu_rd_data;
  end

  assign bus.MEM_DATA_in = mem_data_q;

`ifdef PPU_MEM_DMA_EN
  typedef enum logic [1:0] {DMA_IDLE, DMA_START, DMA_READ, DMA_WRITE} dma_state_t;

  dma_state_t dma_state, dma_state_n;
  logic [7:0] dma_idx_n, dma_src_n;
  logic       ff46_wr;

  assign cpu_ff46_hit = (bus.ADDR == 16'hFF46);
  assign ff46_wr      = bus.WR && cpu_ff46_hit;

  // DMA state, byte index and FF46 shadow (source page).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dma_state <= DMA_IDLE;
      dma_idx   <= '0;
      dma_src   <= '0;
    end else begin
      dma_state <= dma_state_n;
      dma_idx   <= dma_idx_n;
      dma_src   <= dma_src_n;
    end
  end

  // DMA sequencing: one dead START cycle, then READ/WRITE pairs per byte.
  // An FF46 write in any state restarts from index 0 with the new page.
  always_comb begin
    dma_state_n = dma_state;
    dma_idx_n   = dma_idx;
    dma_src_n   = dma_src;
    dma_we      = 1'b0;
    case (dma_state)
      DMA_IDLE:  ;
      DMA_START: begin
        dma_idx_n   = '0;
        dma_state_n = DMA_READ;
      end
      DMA_READ:  dma_state_n = DMA_WRITE;
      DMA_WRITE: begin
        dma_we = 1'b1;
        if (dma_idx == OAM_LAST) begin
          dma_idx_n   = '0;
          dma_state_n = DMA_IDLE;
        end else begin
          dma_idx_n   = dma_idx + 8'd1;
          dma_state_n = DMA_READ;
        end
      end
      default:   dma_state_n = DMA_IDLE;
    endcase
    if (ff46_wr) begin
      dma_src_n   = bus.MMIO_DATA_out;
      dma_idx_n   = '0;
      dma_state_n = DMA_START;
    end
  end

  assign dma_active     = (dma_state != DMA_IDLE);
  assign bus.DMA_ACTIVE = dma_active;
  assign bus.DMA_RD     = (dma_state == DMA_READ);
  assign bus.DMA_ADDR   = bus.DMA_RD ? {dma_src, dma_idx} : 16'h0000;
`else
  assign cpu_ff46_hit   = 1'b0;
  assign dma_active     = 1'b0;
  assign dma_we         = 1'b0;
  assign dma_idx        = 8'h00;
  assign dma_src        = 8'h00;
  assign bus.DMA_ACTIVE = 1'b0;
  assign bus.DMA_RD     = 1'b0;
  assign bus.DMA_ADDR   = 16'h0000;
`endif

endmodule

// File: tb/tb_ppu_vram_oam_responder.sv
// Directed bench for ppu_vram_oam_responder: CPU vector table, PPU latency
// sequences, collisions, reset, and (with PPU_MEM_DMA_EN) the DMA engine.
module tb_ppu_vram_oam_responder;
  logic clk;
  logic rst;

  ppu_vram_oam_responder_if bus();

  ppu_vram_oam_responder #(.VRAM_AW(13), .OAM_SIZE(160)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        lcd;
    logic [1:0]  mode;
    logic        wr;
    logic        rd;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        exp_hit;
    logic [7:0]  exp_data;
  } cpu_vec_t;

`ifdef PPU_MEM_DMA_EN
  localparam logic       FF46_HIT  = 1'b1;
  localparam logic [7:0] FF46_READ = 8'h00;
`else
  localparam logic       FF46_HIT  = 1'b0;
  localparam logic [7:0] FF46_READ = 8'hFF;
`endif

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] ppu_exp;
  logic [7:0] exp_src  = 8'h00;
  int         exp_idx  = 0;
  cpu_vec_t   vecs[$];
  logic       hit;
  logic [7:0] rdata;
  int         cycles;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // System memory seen by the DMA engine.
  function automatic logic [7:0] dma_mem(input logic [15:0] a);
    return a[7:0] ^ ((a[15:8] == 8'hC0) ? 8'h5A : 8'hA5);
  endfunction

  // System-bus model: answers each DMA_RD with data valid in the next cycle,
  // and checks the source address sweep.
  always @(negedge clk) begin
    if (bus.DMA_RD === 1'b1) begin
      check("dma_addr", bus.DMA_ADDR, {exp_src, 8'(exp_idx)});
      bus.DMA_DATA = dma_mem(bus.DMA_ADDR);
      exp_idx++;
    end
  end

  // One CPU access: drive for one edge, sample MEM_HIT while driven and
  // MEM_DATA_in after the edge. Returns on the negedge after the capture edge.
  task automatic cpu_op(input logic lcd, input logic [1:0] mode, input logic wr, input logic rd,
                        input logic [15:0] addr, input logic [7:0] wd,
                        output logic hit_o, output logic [7:0] data_o);
    @(negedge clk);
    bus.LCD_EN = lcd;  bus.PPU_MODE = mode;
    bus.WR = wr;  bus.RD = rd;  bus.ADDR = addr;  bus.MMIO_DATA_out = wd;
    #1 hit_o = bus.MEM_HIT;
    @(posedge clk);
    #1;
    if (wr && addr == 16'hFF46) begin
      exp_src = wd;
      exp_idx = 0;
    end
    @(negedge clk);
    data_o = bus.MEM_DATA_in;
    bus.WR = 1'b0;  bus.RD = 1'b0;
  endtask

  // Single PPU read: old value one cycle after the sample edge, new value
  // after the second edge, then held with PPU_RD low.
  task automatic ppu_read(input logic [15:0] a, input logic [7:0] exp, input string nm);
    @(negedge clk);
    bus.PPU_RD = 1'b1;  bus.PPU_ADDR = a;
    @(negedge clk);
    bus.PPU_RD = 1'b0;
    check({nm, "_early"}, 16'(bus.PPU_DATA_in), 16'(ppu_exp));
    @(negedge clk);
    check(nm, 16'(bus.PPU_DATA_in), 16'(exp));
    repeat (3) @(negedge clk);
    check({nm, "_hold"}, 16'(bus.PPU_DATA_in), 16'(exp));
    ppu_exp = exp;
  endtask

  task automatic wait_dma_done(output int n);
    n = 0;
    while (bus.DMA_ACTIVE === 1'b1 && n < 2000) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.LCD_EN = 1'b1;  bus.PPU_MODE = 2'd0;  bus.PPU_RD = 1'b0;  bus.PPU_ADDR = 16'h0000;
    bus.ADDR = 16'h0000;  bus.RD = 1'b0;  bus.WR = 1'b0;  bus.MMIO_DATA_out = 8'h00;
    bus.DMA_DATA = 8'h00;
    ppu_exp = 8'hFF;

    //            lcd mode wr  rd  addr      wdata  hit       data
    vecs.push_back('{1'b1, 2'd0, 1'b1, 1'b0, 16'h8000, 8'h3C, 1'b1,     8'h00});
    vecs.push_back('{1'b1, 2'd0, 1'b0, 1'b1, 16'h8000, 8'h00, 1'b1,     8'h3C});
    vecs.push_back('{1'b1, 2'd0, 1'b1, 1'b0, 16'h8010, 8'h55, 1'b1,     8'h00});
    vecs.push_back('{1'b1, 2'd3, 1'b1, 1'b0, 16'h8010, 8'hAA, 1'b1,     8'h00});
    vecs.push_back('{1'b1, 2'd3, 1'b0, 1'b1, 16'h8010, 8'h00, 1'b1,     8'hFF});
    vecs.push_back('{1'b1, 2'd0, 1'b0, 1'b1, 16'h8010, 8'h00, 1'b1,     8'h55});
    vecs.push_back('{1'b1, 2'd0, 1'b1, 1'b0, 16'hFE00, 8'h77, 1'b1,     8'h00});
    vecs.push_back('{1'b1, 2'd0, 1'b1, 1'b0, 16'hFE01, 8'h01, 1'b1,     8'h00});
    vecs.push_back('{1'b1, 2'd2, 1'b1, 1'b0, 16'hFE01, 8'h66, 1'b1,     8'h00});
    vecs.push_back('{1'b1, 2'd2, 1'b0, 1'b1, 16'hFE00, 8'h00, 1'b1,     8'hFF});
    vecs.push_back('{1'b1, 2'd3, 1'b0, 1'b1, 16'hFE00, 8'h00, 1'b1,     8'hFF});
    vecs.push_back('{1'b1, 2'd0, 1'b0, 1'b1, 16'hFE01, 8'h00, 1'b1,     8'h01});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 1'b1, 16'hFE00, 8'h00, 1'b1,     8'h77});
    vecs.push_back('{1'b0, 2'd3, 1'b1, 1'b0, 16'h8020, 8'h12, 1'b1,     8'h00});
    vecs.push_back('{1'b0, 2'd3, 1'b0, 1'b1, 16'h8020, 8'h00, 1'b1,     8'h12});
    vecs.push_back('{1'b1, 2'd1, 1'b1, 1'b0, 16'hFE9F, 8'h9F, 1'b1,     8'h00});
    vecs.push_back('{1'b1, 2'd1, 1'b0, 1'b1, 16'hFE9F, 8'h00, 1'b1,     8'h9F});
    vecs.push_back('{1'b1, 2'd1, 1'b1, 1'b0, 16'hFEA0, 8'h11, 1'b0,     8'h00});
    vecs.push_back('{1'b1, 2'd1, 1'b0, 1'b1, 16'hFEA0, 8'h00, 1'b0,     8'hFF});
    vecs.push_back('{1'b1, 2'd1, 1'b0, 1'b1, 16'h7FFF, 8'h00, 1'b0,     8'hFF});
    vecs.push_back('{1'b1, 2'd1, 1'b0, 1'b1, 16'hA000, 8'h00, 1'b0,     8'hFF});
    vecs.push_back('{1'b1, 2'd1, 1'b1, 1'b0, 16'h9FFF, 8'hE7, 1'b1,     8'h00});
    vecs.push_back('{1'b1, 2'd2, 1'b0, 1'b1, 16'h9FFF, 8'h00, 1'b1,     8'hE7});
    vecs.push_back('{1'b1, 2'd0, 1'b0, 1'b1, 16'hFF46, 8'h00, FF46_HIT, FF46_READ});
    vecs.push_back('{1'b1, 2'd0, 1'b1, 1'b0, 16'h8030, 8'h5A, 1'b1,     8'h00});

    // Reset values while reset is held.
    repeat (2) @(negedge clk);
    check("rst_ppu_data", 16'(bus.PPU_DATA_in), 16'h00FF);
    check("rst_mem_data", 16'(bus.MEM_DATA_in), 16'h00FF);
    check("rst_dma_rd",   16'(bus.DMA_RD),      16'h0000);
    check("rst_dma_addr", bus.DMA_ADDR,         16'h0000);
    check("rst_dma_act",  16'(bus.DMA_ACTIVE),  16'h0000);
    check("rst_hit",      16'(bus.MEM_HIT),     16'h0000);
    rst = 1'b0;

    // CPU access table.
    for (int i = 0; i < vecs.size(); i++) begin
      cpu_op(vecs[i].lcd, vecs[i].mode, vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, hit, rdata);
      check($sformatf("vec%0d_hit", i), 16'(hit), 16'(vecs[i].exp_hit));
      if (vecs[i].rd) check($sformatf("vec%0d_data", i), 16'(rdata), 16'(vecs[i].exp_data));
    end

    // PPU latency/hold, and PPU reads never blocked by mode.
    bus.LCD_EN = 1'b1;  bus.PPU_MODE = 2'd0;
    ppu_read(16'h8000, 8'h3C, "ppu_8000");
    bus.PPU_MODE = 2'd3;
    ppu_read(16'h8010, 8'h55, "ppu_vram_mode3");
    for (int m = 0; m < 4; m++) begin
      bus.PPU_MODE = 2'(m);
      ppu_read(16'hFE00, 8'h77, $sformatf("ppu_oam_mode%0d", m));
      ppu_read(16'hFEA0, 8'hFF, $sformatf("ppu_unmapped_mode%0d", m));
    end
    ppu_read(16'h0000, 8'hFF, "ppu_0000");

    // Back-to-back PPU reads: one result per cycle.
    @(negedge clk);  bus.PPU_RD = 1'b1;  bus.PPU_ADDR = 16'h8000;
    @(negedge clk);  bus.PPU_ADDR = 16'h8010;
    check("b2b_early", 16'(bus.PPU_DATA_in), 16'(ppu_exp));
    @(negedge clk);  bus.PPU_ADDR = 16'hFE00;
    check("b2b_0", 16'(bus.PPU_DATA_in), 16'h003C);
    @(negedge clk);  bus.PPU_RD = 1'b0;
    check("b2b_1", 16'(bus.PPU_DATA_in), 16'h0055);
    @(negedge clk);
    check("b2b_2", 16'(bus.PPU_DATA_in), 16'h0077);
    ppu_exp = 8'h77;

    // CPU write and PPU read of the same VRAM byte on one edge: PPU sees old data.
    @(negedge clk);
    bus.PPU_MODE = 2'd0;  bus.PPU_RD = 1'b1;  bus.PPU_ADDR = 16'h8030;
    bus.WR = 1'b1;  bus.ADDR = 16'h8030;  bus.MMIO_DATA_out = 8'hC3;
    @(negedge clk);
    bus.PPU_RD = 1'b0;  bus.WR = 1'b0;
    @(negedge clk);
    check("rbw_old", 16'(bus.PPU_DATA_in), 16'h005A);
    ppu_exp = 8'h5A;
    ppu_read(16'h8030, 8'hC3, "rbw_new");

`ifdef PPU_MEM_DMA_EN
    // Full copy from C000.
    cpu_op(1'b1, 2'd0, 1'b1, 1'b0, 16'hFF46, 8'hC0, hit, rdata);
    check("dma_ff46_hit", 16'(hit), 16'h0001);
    wait_dma_done(cycles);
    check("dma_cycles", 16'(cycles), 16'd321);
    check("dma_bytes",  16'(exp_idx), 16'd160);
    for (int i = 0; i < 160; i++) begin
      cpu_op(1'b0, 2'd0, 1'b0, 1'b1, 16'hFE00 + 16'(i), 8'h00, hit, rdata);
      check($sformatf("oam_c0_%0d", i), 16'(rdata), 16'(8'(i) ^ 8'h5A));
    end
    cpu_op(1'b1, 2'd0, 1'b0, 1'b1, 16'hFF46, 8'h00, hit, rdata);
    check("ff46_shadow", 16'(rdata), 16'h00C0);

    // Restart mid-transfer; OAM locked to CPU and PPU while active.
    cpu_op(1'b1, 2'd0, 1'b1, 1'b0, 16'hFF46, 8'hC0, hit, rdata);
    repeat (50) @(negedge clk);
    cpu_op(1'b0, 2'd0, 1'b0, 1'b1, 16'hFE00, 8'h00, hit, rdata);
    check("dma_cpu_oam_lock", 16'(rdata), 16'h00FF);
    bus.LCD_EN = 1'b0;
    ppu_read(16'hFE00, 8'hFF, "dma_ppu_oam_lock");
    cpu_op(1'b1, 2'd0, 1'b1, 1'b0, 16'hFF46, 8'hD0, hit, rdata);
    wait_dma_done(cycles);
    check("restart_cycles", 16'(cycles), 16'd321);
    check("restart_bytes",  16'(exp_idx), 16'd160);
    for (int i = 0; i < 160; i++) begin
      cpu_op(1'b0, 2'd0, 1'b0, 1'b1, 16'hFE00 + 16'(i), 8'h00, hit, rdata);
      check($sformatf("oam_d0_%0d", i), 16'(rdata), 16'(8'(i) ^ 8'hA5));
    end
`else
    // Without the DMA engine an FF46 write does nothing.
    cpu_op(1'b1, 2'd0, 1'b1, 1'b0, 16'hFF46, 8'hC0, hit, rdata);
    check("nodma_ff46_hit", 16'(hit), 16'h0000);
    repeat (3) @(negedge clk);
    check("nodma_active", 16'(bus.DMA_ACTIVE), 16'h0000);
    check("nodma_rd",     16'(bus.DMA_RD),     16'h0000);
    check("nodma_addr",   bus.DMA_ADDR,        16'h0000);
`endif

    // Asynchronous reset with a PPU read in flight (and a DMA in progress).
    cpu_op(1'b0, 2'd0, 1'b0, 1'b1, 16'h8000, 8'h00, hit, rdata);
    check("pre_rst_cpu", 16'(rdata), 16'h003C);
    ppu_read(16'h8000, 8'h3C, "pre_rst_ppu");
`ifdef PPU_MEM_DMA_EN
    cpu_op(1'b1, 2'd0, 1'b1, 1'b0, 16'hFF46, 8'hC0, hit, rdata);
    repeat (30) @(negedge clk);
    check("pre_rst_dma_act", 16'(bus.DMA_ACTIVE), 16'h0001);
`endif
    @(negedge clk);
    bus.PPU_RD = 1'b1;  bus.PPU_ADDR = 16'h8010;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_ppu_data", 16'(bus.PPU_DATA_in), 16'h00FF);
    check("async_mem_data", 16'(bus.MEM_DATA_in), 16'h00FF);
    check("async_dma_act",  16'(bus.DMA_ACTIVE),  16'h0000);
    check("async_dma_rd",   16'(bus.DMA_RD),      16'h0000);
    check("async_dma_addr", bus.DMA_ADDR,         16'h0000);
    @(negedge clk);  bus.PPU_RD = 1'b0;
    @(negedge clk);  rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_ppu_flushed", 16'(bus.PPU_DATA_in), 16'h00FF);
    ppu_exp = 8'hFF;
    cpu_op(1'b0, 2'd0, 1'b0, 1'b1, 16'h8000, 8'h00, hit, rdata);
    check("post_rst_vram_kept", 16'(rdata), 16'h003C);
`ifdef PPU_MEM_DMA_EN
    cpu_op(1'b1, 2'd0, 1'b0, 1'b1, 16'hFF46, 8'h00, hit, rdata);
    check("post_rst_shadow", 16'(rdata), 16'h0000);
    cpu_op(1'b1, 2'd0, 1'b1, 1'b0, 16'hFF46, 8'hC0, hit, rdata);
    wait_dma_done(cycles);
    check("post_rst_cycles", 16'(cycles), 16'd321);
    check("post_rst_bytes",  16'(exp_idx), 16'd160);
    for (int i = 0; i < 160; i += 53) begin
      cpu_op(1'b0, 2'd0, 1'b0, 1'b1, 16'hFE00 + 16'(i), 8'h00, hit, rdata);
      check($sformatf("post_rst_oam_%0d", i), 16'(rdata), 16'(8'(i) ^ 8'h5A));
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
